mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge.sv | 156 +++++++++++++++
 tb/tb_mem_bus_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: stalls the core's load/store and runs one external bus
// access per request, with byte-lane steering, timeout abort and sticky error.
module mem_bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusReq,
  output logic        BusWe,
  output logic [29:0] BusAddr,
  output logic [31:0] BusWdata,
  output logic [3:0]  BusBe,
  input  logic        BusAck,
  input  logic [31:0] BusRdata,
  output logic        BusErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // Last BUSY cycle index before the access is abandoned.
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic        r_byte;
  logic        r_ok;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;
  logic        w_req;
  logic        w_tmo;
  logic [7:0]  w_lane;

  assign w_req = MemRead | MemWrite;
  assign w_tmo = (r_state == S_BUSY) && !BusAck && (r_cnt == TMAX);

  // Next-state logic; ack has priority over timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_BUSY;
      S_BUSY: if (BusAck || w_tmo) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Request capture, read-data capture, timeout counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= MemWrite;
            r_byte  <= MemByte;
            r_addr  <= Addr;
            r_wdata <= MemByte ? {4{WriteData[7:0]}} : WriteData;
            r_be    <= MemByte ? (4'b0001 << Addr[1:0]) : 4'hF;
            r_ok    <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (BusAck) begin
            r_rdata <= BusRdata;
            r_ok    <= 1'b1;
            r_cnt   <= '0;
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte lane selected by the captured low address bits.
  always_comb begin
    w_lane = r_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_lane = r_rdata[7:0];
      2'd1: w_lane = r_rdata[15:8];
      2'd2: w_lane = r_rdata[23:16];
      2'd3: w_lane = r_rdata[31:24];
      default: w_lane = r_rdata[7:0];
    endcase
  end

  // Output decode; bus fields only driven while an access is in flight.
  always_comb begin
    ReadData = '0;
    Stall    = 1'b0;
    BusReq   = 1'b0;
    BusWe    = 1'b0;
    BusAddr  = '0;
    BusWdata = '0;
    BusBe    = '0;
    if (!reset) begin
      case (r_state)
        S_IDLE: Stall = w_req;
        S_BUSY: begin
          Stall    = 1'b1;
          BusReq   = 1'b1;
          BusWe    = r_we;
          BusAddr  = r_addr[31:2];
          BusWdata = r_wdata;
          BusBe    = r_be;
        end
        S_DONE: begin
          if (r_ok && !r_we)
            ReadData = r_byte ? {24'd0, w_lane} : r_rdata;
        end
        default: ;
      endcase
    end
  end

  assign BusErr = r_err;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed checks of mem_bus_bridge with TIMEOUT = 4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic        MemByte;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        BusReq;
  logic        BusWe;
  logic [29:0] BusAddr;
  logic [31:0] BusWdata;
  logic [3:0]  BusBe;
  logic        BusAck;
  logic [31:0] BusRdata;
  logic        BusErr;

  int n_pass = 0;
  int n_total = 0;

  mem_bus_bridge #(.TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .MemByte(MemByte),
    .Addr(Addr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .Stall(Stall),
    .BusReq(BusReq),
    .BusWe(BusWe),
    .BusAddr(BusAddr),
    .BusWdata(BusWdata),
    .BusBe(BusBe),
    .BusAck(BusAck),
    .BusRdata(BusRdata),
    .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemByte  = 1'b0;
    BusAck   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    MemByte   = 1'b0;
    Addr      = 32'h0;
    WriteData = 32'h0;
    BusAck    = 1'b0;
    BusRdata  = 32'h0;

    // Reset: everything quiet even with a request pending.
    tick();
    tick();
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_req", 32'(BusReq), 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_err", 32'(BusErr), 32'd0);
    check("rst_be", 32'(BusBe), 32'd0);
    idle_inputs();
    reset = 1'b0;
    tick();

    // Word store 0x104 <- CAFEF00D, ack in 2nd BUSY cycle.
    MemWrite  = 1'b1;
    Addr      = 32'h104;
    WriteData = 32'hCAFEF00D;
    #1;
    check("ws_stall_idle", 32'(Stall), 32'd1);
    check("ws_req_idle", 32'(BusReq), 32'd0);
    tick();
    MemWrite = 1'b0;
    check("ws_req_b1", 32'(BusReq), 32'd1);
    check("ws_addr", 32'(BusAddr), 32'h41);
    check("ws_be", 32'(BusBe), 32'hF);
    check("ws_we", 32'(BusWe), 32'd1);
    check("ws_wdata", BusWdata, 32'hCAFEF00D);
    check("ws_stall_b1", 32'(Stall), 32'd1);
    tick();
    check("ws_stall_b2", 32'(Stall), 32'd1);
    check("ws_addr_b2", 32'(BusAddr), 32'h41);
    BusAck = 1'b1;
    tick();
    BusAck = 1'b0;
    check("ws_stall_done", 32'(Stall), 32'd0);
    check("ws_req_done", 32'(BusReq), 32'd0);
    check("ws_rdata_done", ReadData, 32'd0);
    tick();

    // Byte load from 0x203, lane 3 of A1B2C3D4.
    MemRead = 1'b1;
    MemByte = 1'b1;
    Addr    = 32'h203;
    tick();
    idle_inputs();
    check("bl_be", 32'(BusBe), 32'h8);
    check("bl_we", 32'(BusWe), 32'd0);
    check("bl_addr", 32'(BusAddr), 32'h80);
    BusAck   = 1'b1;
    BusRdata = 32'hA1B2C3D4;
    tick();
    BusAck = 1'b0;
    check("bl_rdata", ReadData, 32'h000000A1);
    check("bl_err", 32'(BusErr), 32'd0);
    tick();
    check("bl_rdata_idle", ReadData, 32'd0);

    // Byte store 0x11 <- 7F replicated.
    MemWrite  = 1'b1;
    MemByte   = 1'b1;
    Addr      = 32'h11;
    WriteData = 32'h1234567F;
    tick();
    idle_inputs();
    check("bs_be", 32'(BusBe), 32'h2);
    check("bs_wdata", BusWdata, 32'h7F7F7F7F);
    check("bs_addr", 32'(BusAddr), 32'h4);
    BusAck = 1'b1;
    tick();
    BusAck = 1'b0;
    check("bs_rdata", ReadData, 32'd0);
    tick();

    // Stray ack in IDLE does nothing.
    BusAck = 1'b1;
    tick();
    BusAck = 1'b0;
    check("ack_idle_req", 32'(BusReq), 32'd0);
    check("ack_idle_stall", 32'(Stall), 32'd0);

    // Timeout: word read of 0x40 with no ack.
    MemRead = 1'b1;
    Addr    = 32'h40;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), 32'(BusReq), 32'd1);
      check($sformatf("to_err_%0d", i), 32'(BusErr), 32'd0);
      tick();
    end
    check("to_req_done", 32'(BusReq), 32'd0);
    check("to_stall_done", 32'(Stall), 32'd0);
    check("to_err_done", 32'(BusErr), 32'd1);
    check("to_rdata_done", ReadData, 32'd0);
    tick();

    // Access after timeout still completes; error stays set.
    MemRead = 1'b1;
    Addr    = 32'h44;
    tick();
    idle_inputs();
    check("pt_addr", 32'(BusAddr), 32'h11);
    BusAck   = 1'b1;
    BusRdata = 32'h11223344;
    tick();
    BusAck = 1'b0;
    check("pt_rdata", ReadData, 32'h11223344);
    check("pt_err", 32'(BusErr), 32'd1);
    tick();

    // Reset in the 2nd BUSY cycle.
    MemRead = 1'b1;
    Addr    = 32'h80;
    tick();
    idle_inputs();
    tick();
    check("mr_req_b2", 32'(BusReq), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_req_async", 32'(BusReq), 32'd0);
    check("mr_stall_async", 32'(Stall), 32'd0);
    check("mr_err_clr", 32'(BusErr), 32'd0);
    BusAck   = 1'b1;
    BusRdata = 32'h55555555;
    tick();
    reset = 1'b0;
    tick();
    BusAck = 1'b0;
    check("mr_late_ack_req", 32'(BusReq), 32'd0);
    check("mr_late_ack_rdata", ReadData, 32'd0);

    // Fresh access: ack coincides with the 4th (timeout) BUSY cycle.
    MemRead = 1'b1;
    Addr    = 32'h100;
    tick();
    idle_inputs();
    check("at_addr", 32'(BusAddr), 32'h40);
    tick();
    tick();
    check("at_req_b3", 32'(BusReq), 32'd1);
    tick();
    check("at_req_b4", 32'(BusReq), 32'd1);
    BusAck   = 1'b1;
    BusRdata = 32'hDEADBEEF;
    tick();
    BusAck = 1'b0;
    check("at_rdata", ReadData, 32'hDEADBEEF);
    check("at_err", 32'(BusErr), 32'd0);
    tick();

    // Read and write together: treated as a word write.
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Addr      = 32'h8;
    WriteData = 32'h00000055;
    tick();
    check("rw_we", 32'(BusWe), 32'd1);
    check("rw_be", 32'(BusBe), 32'hF);
    check("rw_addr", 32'(BusAddr), 32'h2);
    BusAck   = 1'b1;
    BusRdata = 32'hFFFFFFFF;
    tick();
    BusAck = 1'b0;
    check("rw_rdata", ReadData, 32'd0);
    check("rw_stall_done", 32'(Stall), 32'd0);
    tick();
    // DONE always returns to IDLE; the held request shows as IDLE stall.
    check("rw_idle_req", 32'(BusReq), 32'd0);
    check("rw_idle_stall", 32'(Stall), 32'd1);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
